// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus (CDB) arbiter.
//   ROB_WIDTH    width of a ROB entry index
//   CDB_SRC_ALU  source encoding for the ALU result port
//   CDB_SRC_LSB  source encoding for the LSB result port
//   CDB_ENTRY_W  width of one queued result {rob_id, value}
package cdb_arbiter_pkg;

  localparam int unsigned ROB_WIDTH   = 4;
  localparam int unsigned CDB_ENTRY_W = ROB_WIDTH + 32;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] rob_id;
    logic [31:0]          value;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous result queue used once per CDB source.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push, wdata  enqueue at tail (ignored when full)
//   pop          dequeue head (ignored when empty)
//   flush        empty the queue; wins over push/pop
//   head         entry at the head (valid when !empty)
//   count        number of stored entries, 0..DEPTH
//   full, empty  status flags derived from count
module cdb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares one registered common data bus between the ALU and LSB result ports.
// Each source feeds a small queue; a round-robin arbiter drains one head per cycle.
// Optional feature macro: CDB_BYPASS_EN (empty queue whose input wins arbitration
// goes straight to the CDB registers, latency 1).
// Ports:
//   clk_in, rst_in, rdy_in  clock, sync active-high reset, global ready (low = freeze)
//   clear                   mispredict flush, only when rdy_in
//   alu_ready/rob_id/value  ALU result in;  alu_full  ALU queue full
//   lsb_ready/rob_id/value  LSB result in;  lsb_full  LSB queue full
//   cdb_ready/rob_id/value  registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 alu_ready,
  input  logic [ROB_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]          alu_value,
  output logic                 alu_full,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 lsb_full,
  output logic                 cdb_ready,
  output logic [ROB_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]          cdb_value
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  cdb_entry_t     alu_in, lsb_in, alu_head, lsb_head, grant_entry;
  logic [PTR_W:0] alu_count, lsb_count;
  logic           alu_fifo_full, lsb_fifo_full, alu_empty, lsb_empty;
  logic           alu_req, lsb_req, contend, grant_alu, grant_lsb;
  logic           alu_byp, lsb_byp, act, flush;
  logic           alu_push, alu_pop, lsb_push, lsb_pop;
  logic           rr_last_q;

  assign alu_in   = '{rob_id: alu_rob_id, value: alu_value};
  assign lsb_in   = '{rob_id: lsb_rob_id, value: lsb_value};
  assign alu_full = (alu_count == FULL_COUNT);
  assign lsb_full = (lsb_count == FULL_COUNT);

  always_comb begin
    alu_req = !alu_empty;
    lsb_req = !lsb_empty;
`ifdef CDB_BYPASS_EN
    // An incoming result on an empty queue competes as if it were the head.
    alu_req = alu_req || alu_ready;
    lsb_req = lsb_req || lsb_ready;
`endif
    contend   = alu_req && lsb_req;
    grant_alu = alu_req && (!lsb_req || (rr_last_q == CDB_SRC_LSB));
    grant_lsb = lsb_req && !grant_alu;
`ifdef CDB_BYPASS_EN
    alu_byp = grant_alu && alu_empty;
    lsb_byp = grant_lsb && lsb_empty;
`else
    alu_byp = 1'b0;
    lsb_byp = 1'b0;
`endif
    act      = rdy_in && !clear;
    flush    = rdy_in && clear;
    alu_push = act && alu_ready && !alu_byp && !alu_fifo_full;
    lsb_push = act && lsb_ready && !lsb_byp && !lsb_fifo_full;
    alu_pop  = act && grant_alu && !alu_byp;
    lsb_pop  = act && grant_lsb && !lsb_byp;
    if (grant_alu) grant_entry = alu_byp ? alu_in : alu_head;
    else           grant_entry = lsb_byp ? lsb_in : lsb_head;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_last_q  <= CDB_SRC_LSB;
      cdb_ready  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        cdb_ready <= 1'b0;
      end else begin
        // Round-robin pointer only moves when both sources competed.
        if (contend) rr_last_q <= grant_alu ? CDB_SRC_ALU : CDB_SRC_LSB;
        if (grant_alu || grant_lsb) begin
          cdb_ready  <= 1'b1;
          cdb_rob_id <= grant_entry.rob_id;
          cdb_value  <= grant_entry.value;
        end else begin
          cdb_ready  <= 1'b0;
        end
      end
    end
  end

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CDB_ENTRY_W)
  ) u_alu_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (alu_push),
    .pop   (alu_pop),
    .flush (flush),
    .wdata (alu_in),
    .head  (alu_head),
    .count (alu_count),
    .full  (alu_fifo_full),
    .empty (alu_empty)
  );

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CDB_ENTRY_W)
  ) u_lsb_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .flush (flush),
    .wdata (lsb_in),
    .head  (lsb_head),
    .count (lsb_count),
    .full  (lsb_fifo_full),
    .empty (lsb_empty)
  );

  // A producer firing into a full queue loses its result.
  alu_overflow_a: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && !clear && alu_ready) |-> !alu_full);
  lsb_overflow_a: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && !clear && lsb_ready) |-> !lsb_full);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build; test_single also
// covers the CDB_BYPASS_EN latency).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                 clk_in = 1'b0;
  logic                 rst_in, rdy_in, clear;
  logic                 alu_ready, lsb_ready, alu_full, lsb_full;
  logic [ROB_WIDTH-1:0] alu_rob_id, lsb_rob_id, cdb_rob_id;
  logic [31:0]          alu_value, lsb_value, cdb_value;
  logic                 cdb_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.DEPTH(4)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .alu_ready  (alu_ready),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_full   (alu_full),
    .lsb_ready  (lsb_ready),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_full   (lsb_full),
    .cdb_ready  (cdb_ready),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rdy_in = 1'b1; clear = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0;
    alu_rob_id = '0; alu_value = '0; lsb_rob_id = '0; lsb_value = '0;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cdb_rob_id !== '0 || cdb_value !== '0) begin
      errors++;
      $display("FAIL reset_cdb_data got rob=%0d val=%h want rob=0 val=0", cdb_rob_id, cdb_value);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({cdb_ready, alu_full, lsb_full} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got rdy/af/lf=%b want 000", c,
                 {cdb_ready, alu_full, lsb_full});
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    alu_ready = 1'b1; alu_rob_id = 4'd3; alu_value = 32'h11;
    tick();
    alu_ready = 1'b0;
`ifndef CDB_BYPASS_EN
    checks++;
    if (cdb_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_t1 got cdb_ready=%b want 0", cdb_ready);
    end
    tick();
`endif
    checks++;
    if (cdb_ready !== 1'b1 || cdb_rob_id !== 4'd3 || cdb_value !== 32'h11) begin
      errors++;
      $display("FAIL single_bcast got rdy=%b rob=%0d val=%h want 1 3 00000011",
               cdb_ready, cdb_rob_id, cdb_value);
    end
    tick();
    checks++;
    if (cdb_ready !== 1'b0 || cdb_rob_id !== 4'd3 || cdb_value !== 32'h11) begin
      errors++;
      $display("FAIL single_after got rdy=%b rob=%0d val=%h want 0 3 00000011 (hold)",
               cdb_ready, cdb_rob_id, cdb_value);
    end
  endtask

  task automatic test_alternate();
    int a_n = 0;
    int l_n = 0;
    bit saw_af = 1'b0;
    bit saw_lf = 1'b0;
    logic [ROB_WIDTH-1:0] got_rob[$];
    logic [31:0]          got_val[$];
    logic [ROB_WIDTH-1:0] exp_rob;
    logic [31:0]          exp_val;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (alu_full) saw_af = 1'b1;
      if (lsb_full) saw_lf = 1'b1;
      alu_ready  = (a_n < 8) && !alu_full;
      alu_rob_id = ROB_WIDTH'(a_n);
      alu_value  = 32'(32'h100 + a_n);
      lsb_ready  = (l_n < 8) && !lsb_full;
      lsb_rob_id = ROB_WIDTH'(8 + l_n);
      lsb_value  = 32'(32'h208 + l_n);
      tick();
      if (alu_ready) a_n++;
      if (lsb_ready) l_n++;
      if (cdb_ready) begin
        got_rob.push_back(cdb_rob_id);
        got_val.push_back(cdb_value);
      end
    end
    alu_ready = 1'b0; lsb_ready = 1'b0;
    checks++;
    if (got_rob.size() != 16) begin
      errors++;
      $display("FAIL alt_count got %0d broadcasts want 16", got_rob.size());
    end
    for (int i = 0; i < 16 && i < got_rob.size(); i++) begin
      exp_rob = (i % 2 == 0) ? ROB_WIDTH'(i / 2) : ROB_WIDTH'(8 + i / 2);
      exp_val = (i % 2 == 0) ? 32'(32'h100 + i / 2) : 32'(32'h208 + i / 2);
      checks++;
      if (got_rob[i] !== exp_rob || got_val[i] !== exp_val) begin
        errors++;
        $display("FAIL alt_seq[%0d] got rob=%0d val=%h want rob=%0d val=%h",
                 i, got_rob[i], got_val[i], exp_rob, exp_val);
      end
    end
    checks++;
    if (saw_af !== 1'b1 || saw_lf !== 1'b1) begin
      errors++;
      $display("FAIL alt_full_seen got alu=%b lsb=%b want 1 1", saw_af, saw_lf);
    end
    checks++;
    if (alu_full !== 1'b0 || lsb_full !== 1'b0) begin
      errors++;
      $display("FAIL alt_drained got af=%b lf=%b want 0 0", alu_full, lsb_full);
    end
  endtask

  task automatic test_burst();
    int a_n = 0;
    logic [ROB_WIDTH-1:0] got_rob[$];
    logic [31:0]          got_val[$];
    do_reset();
    for (int c = 0; c < 20; c++) begin
      alu_ready  = (a_n < 5) && !alu_full;
      alu_rob_id = ROB_WIDTH'(1 + a_n);
      alu_value  = 32'(32'hA0 + a_n);
      tick();
      if (alu_ready) a_n++;
      if (cdb_ready) begin
        got_rob.push_back(cdb_rob_id);
        got_val.push_back(cdb_value);
      end
    end
    alu_ready = 1'b0;
    checks++;
    if (got_rob.size() != 5) begin
      errors++;
      $display("FAIL burst_count got %0d want 5", got_rob.size());
    end
    for (int i = 0; i < 5 && i < got_rob.size(); i++) begin
      checks++;
      if (got_rob[i] !== ROB_WIDTH'(1 + i) || got_val[i] !== 32'(32'hA0 + i)) begin
        errors++;
        $display("FAIL burst_seq[%0d] got rob=%0d val=%h want rob=%0d val=%h",
                 i, got_rob[i], got_val[i], 1 + i, 32'hA0 + i);
      end
    end
  endtask

  task automatic test_clear();
    int stale = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_ready = 1'b1; alu_rob_id = ROB_WIDTH'(1 + c); alu_value = 32'(32'h300 + c);
      lsb_ready = 1'b1; lsb_rob_id = ROB_WIDTH'(9 + c); lsb_value = 32'(32'h400 + c);
      tick();
    end
    // Edges: none, A1, L9 granted; A2,A3 and L10,L11 remain queued.
    checks++;
    if (cdb_ready !== 1'b1 || cdb_rob_id !== 4'd9) begin
      errors++;
      $display("FAIL clear_pre got rdy=%b rob=%0d want 1 9", cdb_ready, cdb_rob_id);
    end
    clear = 1'b1; alu_rob_id = 4'd4; lsb_rob_id = 4'd12;
    tick();
    clear = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0;
    checks++;
    if ({cdb_ready, alu_full, lsb_full} !== 3'b000) begin
      errors++;
      $display("FAIL clear_post got rdy/af/lf=%b want 000", {cdb_ready, alu_full, lsb_full});
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cdb_ready) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL clear_stale got %0d broadcasts want 0", stale);
    end
    alu_ready = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h55;
    tick();
    alu_ready = 1'b0;
    tick();
    checks++;
    if (cdb_ready !== 1'b1 || cdb_rob_id !== 4'd5 || cdb_value !== 32'h55) begin
      errors++;
      $display("FAIL clear_fresh got rdy=%b rob=%0d val=%h want 1 5 00000055",
               cdb_ready, cdb_rob_id, cdb_value);
    end
  endtask

  task automatic test_freeze();
    logic [ROB_WIDTH-1:0] exp_rob [4];
    logic                 exp_rdy [4];
    exp_rob[0] = 4'd9;  exp_rob[1] = 4'd2; exp_rob[2] = 4'd10; exp_rob[3] = 4'd10;
    exp_rdy[0] = 1'b1;  exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;  exp_rdy[3] = 1'b0;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      alu_ready = 1'b1; alu_rob_id = ROB_WIDTH'(1 + c); alu_value = 32'(32'h500 + c);
      lsb_ready = 1'b1; lsb_rob_id = ROB_WIDTH'(9 + c); lsb_value = 32'(32'h600 + c);
      tick();
    end
    // CDB shows A1; queues hold A2 and L9,L10; rr_last = ALU.
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      alu_ready = c[0]; lsb_ready = !c[0]; clear = (c == 1);
      alu_rob_id = 4'd7; lsb_rob_id = 4'd14;
      tick();
      checks++;
      if (cdb_ready !== 1'b1 || cdb_rob_id !== 4'd1 || cdb_value !== 32'h500) begin
        errors++;
        $display("FAIL freeze_hold cyc %0d got rdy=%b rob=%0d val=%h want 1 1 00000500",
                 c, cdb_ready, cdb_rob_id, cdb_value);
      end
    end
    rdy_in = 1'b1; clear = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cdb_ready !== exp_rdy[i] || cdb_rob_id !== exp_rob[i]) begin
        errors++;
        $display("FAIL freeze_resume[%0d] got rdy=%b rob=%0d want %b %0d",
                 i, cdb_ready, cdb_rob_id, exp_rdy[i], exp_rob[i]);
      end
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    alu_ready = 1'b0; lsb_ready = 1'b0;
    alu_rob_id = '0; lsb_rob_id = '0; alu_value = '0; lsb_value = '0;
    test_reset();
    test_single();
    test_alternate();
    test_burst();
    test_clear();
    test_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
